// File: rtl/csr_trap_seq.sv
// csr_trap_seq: multi-cycle SYSTEM-instruction sequencer (CSRRx, ECALL, MRET) in front of the CSR file.
// Define CSR_SEQ_MCYCLE_EN to add a local 64-bit mcycle counter at CSR addresses B00/B80.
module csr_trap_seq #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] TRAP_CAUSE = 32'hb
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_is_csr,
    input  logic            in_is_ecall,
    input  logic            in_is_mret,
    input  logic [2:0]      in_funct3,
    input  logic [11:0]     in_csr_addr,
    input  logic [4:0]      in_rs1_idx,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [4:0]      in_rd,
    output logic            r_csr_en,
    output logic [11:0]     r_csr_addr,
    input  logic [XLEN-1:0] r_csr_data,
    output logic            w_csr_en,
    output logic [11:0]     w_csr_addr,
    output logic [XLEN-1:0] w_csr_data,
    output logic            jump_ecall,
    output logic            jump_mret,
    output logic [XLEN-1:0] csr_pc,
    output logic            done,
    output logic            rd_wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_TRAP_RD = 3'd3,
        S_TRAP    = 3'd4,
        S_RET_RD  = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
`ifdef CSR_SEQ_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE  = 12'hB00;
    localparam logic [11:0] A_MCYCLEH = 12'hB80;
`endif

    function automatic logic addr_legal(input logic [11:0] a);
        logic ok;
        case (a)
            A_MSTATUS, A_MTVEC, A_MEPC, A_MCAUSE: ok = 1'b1;
`ifdef CSR_SEQ_MCYCLE_EN
            A_MCYCLE, A_MCYCLEH:                 ok = 1'b1;
`endif
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [11:0]     addr_q, addr_d;
    logic [4:0]      rs1_idx_q, rs1_idx_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] old_q, old_d;
    logic            done_q, done_d;
    logic            rd_wen_q, rd_wen_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] src_s;
    logic [XLEN-1:0] new_s;
    logic            do_write_s;
    logic            is_cnt_s;
    logic [XLEN-1:0] rd_val_s;

    // Read-modify-write datapath; RS/RC with a zero source index or zimm never write.
    always_comb begin
        src_s = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;
        case (funct3_q[1:0])
            2'b01:   new_s = src_s;
            2'b10:   new_s = old_q | src_s;
            2'b11:   new_s = old_q & ~src_s;
            default: new_s = old_q;
        endcase
        do_write_s = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
    end

`ifdef CSR_SEQ_MCYCLE_EN
    logic [2*XLEN-1:0] mcycle_q, mcycle_d;

    assign is_cnt_s = (addr_q == A_MCYCLE) || (addr_q == A_MCYCLEH);
    assign rd_val_s = (addr_q == A_MCYCLEH) ? mcycle_q[2*XLEN-1:XLEN] :
                      (addr_q == A_MCYCLE)  ? mcycle_q[XLEN-1:0] : r_csr_data;

    // Free-running cycle counter; a software write to one half wins over the increment.
    always_comb begin
        if ((state_q == S_WRITE) && is_cnt_s && do_write_s) begin
            if (addr_q == A_MCYCLEH) begin
                mcycle_d = {new_s, mcycle_q[XLEN-1:0]};
            end else begin
                mcycle_d = {mcycle_q[2*XLEN-1:XLEN], new_s};
            end
        end else begin
            mcycle_d = mcycle_q + {{(2*XLEN-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q <= '0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`else
    assign is_cnt_s = 1'b0;
    assign rd_val_s = r_csr_data;
`endif

    assign in_ready = (state_q == S_IDLE) && !rst;

    // CSR-file port strobes decode straight from state and are held off during reset.
    always_comb begin
        r_csr_en   = 1'b0;
        r_csr_addr = 12'h000;
        w_csr_en   = 1'b0;
        w_csr_addr = 12'h000;
        w_csr_data = '0;
        jump_ecall = 1'b0;
        jump_mret  = 1'b0;
        csr_pc     = '0;
        if (!rst) begin
            case (state_q)
                S_READ: begin
                    r_csr_en   = !is_cnt_s;
                    r_csr_addr = addr_q;
                end
                S_WRITE: begin
                    if (do_write_s && !is_cnt_s) begin
                        w_csr_en   = 1'b1;
                        w_csr_addr = addr_q;
                        w_csr_data = new_s;
                    end else begin
                        w_csr_en   = 1'b0;
                    end
                end
                S_TRAP_RD: begin
                    r_csr_en   = 1'b1;
                    r_csr_addr = A_MTVEC;
                end
                S_TRAP: begin
                    jump_ecall = 1'b1;
                    csr_pc     = pc_q;
                end
                S_RET_RD: begin
                    r_csr_en   = 1'b1;
                    r_csr_addr = A_MEPC;
                    jump_mret  = 1'b1;
                end
                default: begin
                    r_csr_en   = 1'b0;
                end
            endcase
        end else begin
            r_csr_en = 1'b0;
        end
    end

    // Next-state and completion-result logic.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        funct3_d         = funct3_q;
        addr_d           = addr_q;
        rs1_idx_d        = rs1_idx_q;
        rs1_data_d       = rs1_data_q;
        rd_d             = rd_q;
        old_d            = old_q;
        done_d           = 1'b0;
        rd_wen_d         = 1'b0;
        redirect_valid_d = 1'b0;
        illegal_d        = 1'b0;
        rd_addr_d        = rd_addr_q;
        rd_data_d        = rd_data_q;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pc_d       = in_pc;
                    funct3_d   = in_funct3;
                    addr_d     = in_csr_addr;
                    rs1_idx_d  = in_rs1_idx;
                    rs1_data_d = in_rs1_data;
                    rd_d       = in_rd;
                    if (in_is_ecall) begin
                        state_d = S_TRAP_RD;
                    end else if (in_is_mret) begin
                        state_d = S_RET_RD;
                    end else if (in_is_csr && (in_funct3[1:0] != 2'b00) && addr_legal(in_csr_addr)) begin
                        state_d = S_READ;
                    end else begin
                        // Illegal CSR op or no class at all: finish at once with no side effects.
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        illegal_d = in_is_csr;
                        rd_addr_d = in_rd;
                        rd_data_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                old_d   = rd_val_s;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                rd_wen_d  = (rd_q != 5'd0);
                rd_addr_d = rd_q;
                rd_data_d = old_q;
            end
            S_TRAP_RD: begin
                old_d   = r_csr_data;
                state_d = S_TRAP;
            end
            S_TRAP: begin
                state_d          = S_DONE;
                done_d           = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = old_q;
                rd_addr_d        = rd_q;
                rd_data_d        = TRAP_CAUSE;
            end
            S_RET_RD: begin
                state_d          = S_DONE;
                done_d           = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = r_csr_data;
                rd_addr_d        = rd_q;
                rd_data_d        = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, latched instruction fields and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            pc_q             <= '0;
            funct3_q         <= 3'b000;
            addr_q           <= 12'h000;
            rs1_idx_q        <= 5'd0;
            rs1_data_q       <= '0;
            rd_q             <= 5'd0;
            old_q            <= '0;
            done_q           <= 1'b0;
            rd_wen_q         <= 1'b0;
            rd_addr_q        <= 5'd0;
            rd_data_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            illegal_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            funct3_q         <= funct3_d;
            addr_q           <= addr_d;
            rs1_idx_q        <= rs1_idx_d;
            rs1_data_q       <= rs1_data_d;
            rd_q             <= rd_d;
            old_q            <= old_d;
            done_q           <= done_d;
            rd_wen_q         <= rd_wen_d;
            rd_addr_q        <= rd_addr_d;
            rd_data_q        <= rd_data_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            illegal_q        <= illegal_d;
        end
    end

    assign done           = done_q;
    assign rd_wen         = rd_wen_q;
    assign rd_addr        = rd_addr_q;
    assign rd_data        = rd_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Self-checking bench for csr_trap_seq: directed scenarios plus randomized ops against a CSR-file model.
`timescale 1ns/1ps
module tb_csr_trap_seq;

    localparam logic [31:0] CAUSE = 32'hb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic        in_is_csr, in_is_ecall, in_is_mret;
    logic [2:0]  in_funct3;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rs1_idx;
    logic [31:0] in_rs1_data;
    logic [4:0]  in_rd;
    logic        r_csr_en;
    logic [11:0] r_csr_addr;
    logic [31:0] r_csr_data;
    logic        w_csr_en;
    logic [11:0] w_csr_addr;
    logic [31:0] w_csr_data;
    logic        jump_ecall, jump_mret;
    logic [31:0] csr_pc;
    logic        done, rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;

    csr_trap_seq #(.XLEN(32), .TRAP_CAUSE(CAUSE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_is_csr(in_is_csr), .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret),
        .in_funct3(in_funct3), .in_csr_addr(in_csr_addr), .in_rs1_idx(in_rs1_idx),
        .in_rs1_data(in_rs1_data), .in_rd(in_rd), .r_csr_en(r_csr_en), .r_csr_addr(r_csr_addr),
        .r_csr_data(r_csr_data), .w_csr_en(w_csr_en), .w_csr_addr(w_csr_addr),
        .w_csr_data(w_csr_data), .jump_ecall(jump_ecall), .jump_mret(jump_mret), .csr_pc(csr_pc),
        .done(done), .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // CSR file model: 0=mstatus(300) 1=mtvec(305) 2=mepc(341) 3=mcause(342)
    logic [31:0] mem [4];

    always_comb begin
        case (r_csr_addr)
            12'h300: r_csr_data = mem[0];
            12'h305: r_csr_data = mem[1];
            12'h341: r_csr_data = mem[2];
            12'h342: r_csr_data = mem[3];
            default: r_csr_data = 32'hDEAD_BEEF;
        endcase
    end

    function automatic int aidx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            default: return -1;
        endcase
    endfunction

    int nvec = 0;
    int nerr = 0;

    // observations of one operation
    int          o_wait, o_done_k, o_r_cnt, o_w_cnt, o_w_k, o_e_cnt, o_e_k, o_m_cnt, o_m_k, o_coll;
    logic [11:0] o_w_addr;
    logic [31:0] o_w_data, o_e_pc, o_rd_data, o_redir_pc;
    logic [4:0]  o_rd_addr;
    logic        o_rd_wen, o_redir, o_illegal;

    // reference expectations of one operation
    int          e_lat, e_r_cnt, e_w_cnt, e_e_cnt, e_m_cnt;
    logic [31:0] e_w_data, e_rd_data, e_redir_pc;
    logic        e_illegal, e_rd_wen, e_chk_rd, e_redir;
    logic [31:0] e_mem [4];

    task automatic model_op(input logic ie, input logic im, input logic ic, input logic [2:0] f3,
                            input logic [11:0] a, input logic [4:0] ri, input logic [31:0] rdat,
                            input logic [4:0] rdi, input logic [31:0] pc);
        logic [31:0] src, oldv, nv;
        int ix;
        for (int i = 0; i < 4; i++) e_mem[i] = mem[i];
        e_r_cnt = 0; e_w_cnt = 0; e_e_cnt = 0; e_m_cnt = 0; e_w_data = 0;
        e_illegal = 0; e_rd_wen = 0; e_rd_data = 0; e_chk_rd = 0; e_redir = 0; e_redir_pc = 0;
        ix = aidx(a);
        if (ie) begin
            e_lat = 3; e_r_cnt = 1; e_e_cnt = 1; e_redir = 1; e_redir_pc = mem[1];
            e_mem[2] = pc; e_mem[3] = CAUSE;
        end else if (im) begin
            e_lat = 2; e_r_cnt = 1; e_m_cnt = 1; e_redir = 1; e_redir_pc = mem[2];
        end else if (ic && f3 != 3'd0 && f3 != 3'd4 && ix >= 0) begin
            e_lat = 3; e_r_cnt = 1; oldv = mem[ix];
            src = (f3 >= 3'd4) ? 32'(ri) : rdat;
            if (f3 % 4 == 1)      nv = src;
            else if (f3 % 4 == 2) nv = oldv | src;
            else                  nv = oldv & ~src;
            e_rd_wen = (rdi != 5'd0); e_rd_data = oldv; e_chk_rd = 1;
            if (f3 % 4 == 1 || ri != 5'd0) begin
                e_w_cnt = 1; e_w_data = nv; e_mem[ix] = nv;
            end
        end else begin
            e_lat = 1; e_illegal = ic;
        end
    endtask

    // Issue one instruction (called at a negedge) and record what the DUT does until done.
    task automatic do_op(input logic ie, input logic im, input logic ic, input logic [2:0] f3,
                         input logic [11:0] a, input logic [4:0] ri, input logic [31:0] rdat,
                         input logic [4:0] rdi, input logic [31:0] pc);
        int ix;
        in_is_ecall = ie; in_is_mret = im; in_is_csr = ic; in_funct3 = f3; in_csr_addr = a;
        in_rs1_idx = ri; in_rs1_data = rdat; in_rd = rdi; in_pc = pc; in_valid = 1'b1;
        o_wait = 0;
        while (!in_ready && o_wait < 4) begin
            @(negedge clk);
            o_wait++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_is_ecall = 1'($urandom); in_is_mret = 1'($urandom); in_is_csr = 1'($urandom);
        in_funct3 = 3'($urandom); in_csr_addr = 12'($urandom); in_rs1_idx = 5'($urandom);
        in_rs1_data = $urandom; in_rd = 5'($urandom); in_pc = $urandom;
        o_done_k = 0; o_r_cnt = 0; o_w_cnt = 0; o_w_k = 0; o_e_cnt = 0; o_e_k = 0;
        o_m_cnt = 0; o_m_k = 0; o_coll = 0; o_w_addr = 0; o_w_data = 0; o_e_pc = 0;
        o_rd_wen = 0; o_rd_addr = 0; o_rd_data = 0; o_redir = 0; o_redir_pc = 0; o_illegal = 0;
        for (int k = 1; k <= 8 && o_done_k == 0; k++) begin
            @(negedge clk);
            if (int'(r_csr_en) + int'(w_csr_en) + int'(jump_ecall) > 1) o_coll++;
            if (r_csr_en) o_r_cnt++;
            if (w_csr_en) begin
                o_w_cnt++; o_w_k = k; o_w_addr = w_csr_addr; o_w_data = w_csr_data;
                ix = aidx(w_csr_addr);
                if (ix >= 0) mem[ix] = w_csr_data;
            end
            if (jump_ecall) begin
                o_e_cnt++; o_e_k = k; o_e_pc = csr_pc; mem[2] = csr_pc; mem[3] = CAUSE;
            end
            if (jump_mret) begin
                o_m_cnt++; o_m_k = k;
            end
            if (done) begin
                o_done_k = k; o_rd_wen = rd_wen; o_rd_addr = rd_addr; o_rd_data = rd_data;
                o_redir = redirect_valid; o_redir_pc = redirect_pc; o_illegal = illegal;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_is_csr = 1'b1; in_is_ecall = 1'b0; in_is_mret = 1'b0;
        in_funct3 = 3'b001; in_csr_addr = 12'h300; in_rs1_idx = 5'd1; in_rs1_data = 32'h1;
        in_rd = 5'd1; in_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        nvec++; if ({done, rd_wen, redirect_valid, illegal} !== 4'b0000) begin nerr++; $display("FAIL rst_flags: got %b want 0000", {done, rd_wen, redirect_valid, illegal}); end
        nvec++; if ({rd_addr, rd_data, redirect_pc} !== 69'd0) begin nerr++; $display("FAIL rst_data: got %h/%h/%h want 0", rd_addr, rd_data, redirect_pc); end
        nvec++; if ({r_csr_en, w_csr_en, jump_ecall, jump_mret} !== 4'b0000) begin nerr++; $display("FAIL rst_ports: got %b want 0000", {r_csr_en, w_csr_en, jump_ecall, jump_mret}); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_csrrw();
        @(negedge clk);
        mem[1] = 32'h0;
        do_op(1'b0, 1'b0, 1'b1, 3'b001, 12'h305, 5'd10, 32'h8000_0100, 5'd5, 32'h8000_0000);
        nvec++; if (o_w_cnt !== 1 || o_w_k !== 2) begin nerr++; $display("FAIL csrrw_wr: got cnt=%0d at=%0d want 1 at 2", o_w_cnt, o_w_k); end
        nvec++; if (o_w_addr !== 12'h305 || o_w_data !== 32'h8000_0100) begin nerr++; $display("FAIL csrrw_wdata: got %h:%h want 305:80000100", o_w_addr, o_w_data); end
        nvec++; if (o_done_k !== 3) begin nerr++; $display("FAIL csrrw_lat: got %0d want 3", o_done_k); end
        nvec++; if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd5 || o_rd_data !== 32'h0) begin nerr++; $display("FAIL csrrw_rd: got %b/%0d/%h want 1/5/0", o_rd_wen, o_rd_addr, o_rd_data); end
        nvec++; if (mem[1] !== 32'h8000_0100) begin nerr++; $display("FAIL csrrw_mtvec: got %h want 80000100", mem[1]); end
    endtask

    task automatic test_csrrs_x0();
        mem[0] = 32'h1800;
        do_op(1'b0, 1'b0, 1'b1, 3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h8000_0004);
        nvec++; if (o_w_cnt !== 0) begin nerr++; $display("FAIL csrrs_nowrite: got %0d writes want 0", o_w_cnt); end
        nvec++; if (o_rd_wen !== 1'b0 || o_illegal !== 1'b0) begin nerr++; $display("FAIL csrrs_flags: got rd_wen=%b illegal=%b want 0/0", o_rd_wen, o_illegal); end
        nvec++; if (o_done_k !== 3 || o_rd_data !== 32'h1800) begin nerr++; $display("FAIL csrrs_old: got lat=%0d data=%h want 3/1800", o_done_k, o_rd_data); end
    endtask

    task automatic test_ecall();
        mem[1] = 32'h8000_0100;
        do_op(1'b1, 1'b0, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0040);
        nvec++; if (o_e_cnt !== 1 || o_e_k !== 2 || o_e_pc !== 32'h8000_0040) begin nerr++; $display("FAIL ecall_jump: got cnt=%0d at=%0d pc=%h want 1/2/80000040", o_e_cnt, o_e_k, o_e_pc); end
        nvec++; if (o_redir !== 1'b1 || o_redir_pc !== 32'h8000_0100) begin nerr++; $display("FAIL ecall_redir: got %b/%h want 1/80000100", o_redir, o_redir_pc); end
        nvec++; if (o_done_k !== 3 || o_rd_wen !== 1'b0 || o_w_cnt !== 0) begin nerr++; $display("FAIL ecall_misc: got lat=%0d rd_wen=%b wr=%0d want 3/0/0", o_done_k, o_rd_wen, o_w_cnt); end
    endtask

    task automatic test_mret();
        mem[2] = 32'h8000_0044;
        do_op(1'b0, 1'b1, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0200);
        nvec++; if (o_m_cnt !== 1 || o_m_k !== 1) begin nerr++; $display("FAIL mret_pulse: got cnt=%0d at=%0d want 1/1", o_m_cnt, o_m_k); end
        nvec++; if (o_done_k !== 2 || o_redir !== 1'b1 || o_redir_pc !== 32'h8000_0044) begin nerr++; $display("FAIL mret_redir: got lat=%0d %b/%h want 2/1/80000044", o_done_k, o_redir, o_redir_pc); end
    endtask

    task automatic test_illegal();
        do_op(1'b0, 1'b0, 1'b1, 3'b011, 12'h7C0, 5'd3, 32'h5, 5'd4, 32'h0);
        nvec++; if (o_illegal !== 1'b1 || o_w_cnt !== 0 || o_r_cnt !== 0) begin nerr++; $display("FAIL illegal_addr: got ill=%b wr=%0d rd=%0d want 1/0/0", o_illegal, o_w_cnt, o_r_cnt); end
        nvec++; if (o_done_k !== 1 || o_rd_wen !== 1'b0) begin nerr++; $display("FAIL illegal_lat: got lat=%0d rd_wen=%b want 1/0", o_done_k, o_rd_wen); end
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL illegal_ready: got %b want 1", in_ready); end
        do_op(1'b0, 1'b0, 1'b1, 3'b100, 12'h300, 5'd3, 32'h5, 5'd4, 32'h0);
        nvec++; if (o_illegal !== 1'b1 || o_w_cnt !== 0 || o_done_k !== 1) begin nerr++; $display("FAIL illegal_f3: got ill=%b wr=%0d lat=%0d want 1/0/1", o_illegal, o_w_cnt, o_done_k); end
        do_op(1'b0, 1'b0, 1'b0, 3'b001, 12'h300, 5'd3, 32'h5, 5'd4, 32'h0);
        nvec++; if (o_done_k !== 1 || {o_illegal, o_rd_wen, o_redir} !== 3'b000 || o_r_cnt !== 0) begin nerr++; $display("FAIL noclass: got lat=%0d flags=%b reads=%0d want 1/000/0", o_done_k, {o_illegal, o_rd_wen, o_redir}, o_r_cnt); end
    endtask

    task automatic test_reset_write();
        logic seen_done, seen_w;
        @(negedge clk);
        mem[3] = 32'h0000_5A5A;
        in_is_ecall = 1'b0; in_is_mret = 1'b0; in_is_csr = 1'b1; in_funct3 = 3'b001;
        in_csr_addr = 12'h342; in_rs1_idx = 5'd2; in_rs1_data = 32'h1234; in_rd = 5'd6; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        seen_done = done; seen_w = w_csr_en;
        @(negedge clk);
        seen_done |= done;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rstw_ready_in_rst: got %b want 0", in_ready); end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_done |= done; seen_w |= w_csr_en;
        end
        nvec++; if (seen_w !== 1'b0 || mem[3] !== 32'h0000_5A5A) begin nerr++; $display("FAIL rstw_abort: got w=%b mcause=%h want 0/5a5a", seen_w, mem[3]); end
        nvec++; if (seen_done !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL rstw_idle: got done=%b ready=%b want 0/1", seen_done, in_ready); end
        do_op(1'b0, 1'b0, 1'b1, 3'b001, 12'h342, 5'd2, 32'h77, 5'd7, 32'h0);
        nvec++; if (o_done_k !== 3 || o_rd_data !== 32'h0000_5A5A || mem[3] !== 32'h77) begin nerr++; $display("FAIL rstw_after: got lat=%0d old=%h new=%h want 3/5a5a/77", o_done_k, o_rd_data, mem[3]); end
    endtask

    task automatic test_back_to_back();
        do_op(1'b0, 1'b0, 1'b1, 3'b101, 12'h342, 5'd17, 32'h0, 5'd1, 32'h0);
        do_op(1'b0, 1'b0, 1'b1, 3'b110, 12'h342, 5'd0, 32'h0, 5'd9, 32'h0);
        nvec++; if (o_wait !== 1 || o_rd_data !== 32'd17 || o_rd_wen !== 1'b1) begin nerr++; $display("FAIL b2b_second: got wait=%0d data=%h wen=%b want 1/11/1", o_wait, o_rd_data, o_rd_wen); end
        mem[2] = 32'h8000_0300;
        do_op(1'b0, 1'b1, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h0);
        nvec++; if (o_wait !== 1 || o_redir_pc !== 32'h8000_0300) begin nerr++; $display("FAIL b2b_third: got wait=%0d pc=%h want 1/80000300", o_wait, o_redir_pc); end
    endtask

    task automatic test_random();
        logic        ie, im, ic;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  ri, rdi;
        logic [31:0] rdat, pc;
        logic [11:0] addrs [7];
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342;
        addrs[4] = 12'h7C0; addrs[5] = 12'h301; addrs[6] = 12'h000;
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        for (int n = 0; n < 300; n++) begin
            ie = ($urandom_range(0, 9) == 0); im = ($urandom_range(0, 7) == 0);
            ic = ($urandom_range(0, 9) != 0);
            f3 = 3'($urandom); a = addrs[$urandom_range(0, 6)];
            ri = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rdi = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rdat = $urandom; pc = {$urandom, 2'b00};
            model_op(ie, im, ic, f3, a, ri, rdat, rdi, pc);
            do_op(ie, im, ic, f3, a, ri, rdat, rdi, pc);
            nvec++; if (o_done_k !== e_lat) begin nerr++; $display("FAIL rnd%0d_lat: got %0d want %0d", n, o_done_k, e_lat); end
            nvec++; if (o_illegal !== e_illegal || o_rd_wen !== e_rd_wen || o_redir !== e_redir) begin nerr++; $display("FAIL rnd%0d_flags: got %b%b%b want %b%b%b", n, o_illegal, o_rd_wen, o_redir, e_illegal, e_rd_wen, e_redir); end
            nvec++; if (e_chk_rd && (o_rd_data !== e_rd_data || o_rd_addr !== rdi)) begin nerr++; $display("FAIL rnd%0d_rd: got %0d:%h want %0d:%h", n, o_rd_addr, o_rd_data, rdi, e_rd_data); end
            nvec++; if (e_redir && o_redir_pc !== e_redir_pc) begin nerr++; $display("FAIL rnd%0d_redir_pc: got %h want %h", n, o_redir_pc, e_redir_pc); end
            nvec++; if (o_w_cnt !== e_w_cnt || (e_w_cnt == 1 && (o_w_data !== e_w_data || o_w_addr !== a || o_w_k !== 2))) begin nerr++; $display("FAIL rnd%0d_write: got %0d %h@%h k%0d want %0d %h@%h", n, o_w_cnt, o_w_data, o_w_addr, o_w_k, e_w_cnt, e_w_data, a); end
            nvec++; if (o_e_cnt !== e_e_cnt || (e_e_cnt == 1 && o_e_pc !== pc) || o_m_cnt !== e_m_cnt) begin nerr++; $display("FAIL rnd%0d_jump: got e=%0d pc=%h m=%0d want e=%0d pc=%h m=%0d", n, o_e_cnt, o_e_pc, o_m_cnt, e_e_cnt, pc, e_m_cnt); end
            nvec++; if (o_r_cnt !== e_r_cnt || o_coll !== 0) begin nerr++; $display("FAIL rnd%0d_ports: got reads=%0d coll=%0d want %0d/0", n, o_r_cnt, o_coll, e_r_cnt); end
            nvec++; if (mem[0] !== e_mem[0] || mem[1] !== e_mem[1] || mem[2] !== e_mem[2] || mem[3] !== e_mem[3]) begin nerr++; $display("FAIL rnd%0d_csrs: got %h %h %h %h want %h %h %h %h", n, mem[0], mem[1], mem[2], mem[3], e_mem[0], e_mem[1], e_mem[2], e_mem[3]); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        test_reset();
        test_csrrw();
        test_csrrs_x0();
        test_ecall();
        test_mret();
        test_illegal();
        test_reset_write();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
